// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma datapath blocks.
// Holds the alphabet geometry and the plugboard state encoding.
package enigma_pkg;

  localparam int ASCII_A   = 65;
  localparam int ALPHA_LEN = 26;
  localparam int TABLE_W   = 208;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } pb_state_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

endpackage

// File: rtl/plug_fifo.sv
// Byte-wide synchronous FIFO buffering host characters for the plugboard.
// DEPTH must be a power of two so the pointers wrap naturally.
module plug_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot this push lands in, so full does not block it
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/plugboard.sv
// Enigma plugboard: buffers host letters, swaps them and issues one at a time.
// Define PLUGBOARD_LOWERCASE_EN to accept and fold lowercase letters.
module plugboard
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic [TABLE_W-1:0] pairs,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               rotor_done,
  output logic               busy,
  output logic               in_err
);

  pb_state_t state;

  logic [7:0] tbl [ALPHA_LEN];
  logic [7:0] head;
  logic [7:0] mapped;
  logic [7:0] char_in;
  logic       char_ok;
  logic       xfer;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [$clog2(FIFO_DEPTH):0] count;

  assign in_ready = !full && !reset;
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && char_ok;
  assign pop      = (state == ST_IDLE) && !empty;
  assign busy     = (state != ST_IDLE) || (count != '0);

  always_comb begin
    char_in = in_data;
    char_ok = is_upper(in_data);
`ifdef PLUGBOARD_LOWERCASE_EN
    if (in_data >= 8'h61 && in_data <= 8'h7A) begin
      char_in = in_data - 8'h20;
      char_ok = 1'b1;
    end
`endif
  end

  // non-letter table entries leave their letter unswapped
  always_comb begin
    mapped = head;
    for (int k = 0; k < ALPHA_LEN; k++) begin
      if (head == 8'(ASCII_A + k) && is_upper(tbl[k]))
        mapped = tbl[k];
    end
  end

  plug_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (char_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ALPHA_LEN; k++)
        tbl[k] <= 8'(ASCII_A + k);
    end else if (set) begin
      for (int k = 0; k < ALPHA_LEN; k++)
        tbl[k] <= pairs[TABLE_W-1-8*k -: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      in_err    <= 1'b0;
    end else begin
      in_err    <= xfer && !char_ok;
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            out_data  <= mapped;
            out_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (rotor_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plugboard.sv
// Self-checking bench for plugboard: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_plugboard;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         set = 1'b0;
  logic [207:0] pairs = '0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         rotor_done = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         busy;
  logic         in_err;

  int n_chk = 0;
  int n_fail = 0;
  int ov_seen = 0;

  logic [7:0] drv_tbl [26];

  // reference model state
  logic [7:0] q [$];
  logic [7:0] mtbl [26];
  bit         outstanding = 0;
  int         age = 0;
  logic       m_ov = 0;
  logic       m_err = 0;
  logic [7:0] m_data = 8'h00;

  plugboard #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .pairs      (pairs),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .rotor_done (rotor_done),
    .busy       (busy),
    .in_err     (in_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_up(input logic [7:0] c);
    return c >= "A" && c <= "Z";
  endfunction

  function automatic logic [7:0] lookup(input logic [7:0] h);
    logic [7:0] t;
    t = mtbl[h - 8'd65];
    return is_up(t) ? t : h;
  endfunction

  function automatic logic [207:0] pack_tbl();
    logic [207:0] p;
    for (int k = 0; k < 26; k++) p[207-8*k -: 8] = drv_tbl[k];
    return p;
  endfunction

  task automatic ident_drv();
    for (int k = 0; k < 26; k++) drv_tbl[k] = 8'(65 + k);
    pairs = pack_tbl();
  endtask

  task automatic model_step();
    logic [7:0] c;
    logic [7:0] h;
    bit ok;
    bit xfer;
    if (reset) begin
      q.delete();
      outstanding = 0;
      age = 0;
      m_ov = 0;
      m_err = 0;
      m_data = 8'h00;
      for (int k = 0; k < 26; k++) mtbl[k] = 8'(65 + k);
      return;
    end
    xfer = in_valid && (q.size() < DEPTH);
    c = in_data;
    ok = is_up(c);
`ifdef PLUGBOARD_LOWERCASE_EN
    if (c >= "a" && c <= "z") begin
      c = c - 8'd32;
      ok = 1;
    end
`endif
    m_err = xfer && !ok;
    m_ov = 0;
    if (!outstanding && q.size() > 0) begin
      h = q.pop_front();
      m_data = lookup(h);
      m_ov = 1;
      outstanding = 1;
      age = 0;
    end else if (outstanding) begin
      if (age == 0) age = 1;
      else if (rotor_done) outstanding = 0;
    end
    if (xfer && ok) q.push_back(c);
    if (set)
      for (int k = 0; k < 26; k++) mtbl[k] = pairs[207-8*k -: 8];
  endtask

  initial begin
    for (int k = 0; k < 26; k++) mtbl[k] = 8'(65 + k);
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (out_valid) ov_seen++;
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_data);
      chk("in_err", in_err, m_err);
      chk("in_ready", in_ready, !reset && q.size() < DEPTH);
      chk("busy", busy, outstanding || q.size() != 0);
    end
  end

  task automatic tick();
    bit x;
    x = in_valid && in_ready;
    @(posedge clk);
    #2;
    if (x) in_valid = 1'b0;
  endtask

  task automatic issue_one(input logic [7:0] c, input logic [7:0] exp,
                           input string tag);
    in_data = c;
    in_valid = 1'b1;
    tick();
    tick();
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    tick();
    rotor_done = 1'b1;
    tick();
    rotor_done = 1'b0;
    tick();
  endtask

  initial begin
    int b;
    int r;
    ident_drv();
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 8'h00);
    reset = 1'b0;
    tick();

    // identity table, latency and busy until rotor_done
    in_data = 8'h43;
    in_valid = 1'b1;
    tick();
    chk("c_busy_push", busy, 1);
    tick();
    chk("c_ov", out_valid, 1);
    chk("c_data", out_data, 8'h43);
    repeat (3) begin
      tick();
      chk("c_busy_wait", busy, 1);
    end
    rotor_done = 1'b1;
    tick();
    rotor_done = 1'b0;
    chk("c_busy_done", busy, 0);

    // swap A->Q and Q->A
    drv_tbl[0] = 8'h51;
    drv_tbl[16] = 8'h41;
    pairs = pack_tbl();
    set = 1'b1;
    tick();
    set = 1'b0;
    issue_one("A", 8'h51, "swap_a");
    issue_one("Q", 8'h41, "swap_q");

    // rejected byte then a good one
    b = ov_seen;
    in_data = 8'h31;
    in_valid = 1'b1;
    tick();
    chk("rej_err", in_err, 1);
    in_data = "B";
    in_valid = 1'b1;
    tick();
    chk("rej_err_clr", in_err, 0);
    tick();
    chk("rej_b_ov", out_valid, 1);
    chk("rej_b_data", out_data, 8'h42);
    chk("rej_count", ov_seen - b, 1);
    tick();
    rotor_done = 1'b1;
    tick();
    rotor_done = 1'b0;
    tick();

    // lowercase
`ifdef PLUGBOARD_LOWERCASE_EN
    issue_one(8'h61, 8'h51, "lower");
`else
    b = ov_seen;
    in_data = 8'h61;
    in_valid = 1'b1;
    tick();
    chk("lower_err", in_err, 1);
    repeat (3) tick();
    chk("lower_no_ov", ov_seen - b, 0);
    chk("lower_busy", busy, 0);
`endif

    // back-pressure with rotor stalled
    b = ov_seen;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(68 + i);
      in_valid = 1'b1;
      tick();
    end
    chk("bp_ready_low", in_ready, 0);
    chk("bp_one_issued", ov_seen - b, 1);
    in_data = "I";
    in_valid = 1'b1;
    tick();
    tick();
    chk("bp_stalled", in_ready, 0);
    chk("bp_still_one", ov_seen - b, 1);
    for (int i = 0; i < 5; i++) begin
      b = ov_seen;
      rotor_done = 1'b1;
      tick();
      rotor_done = 1'b0;
      repeat (3) tick();
      chk("bp_release", ov_seen - b, 1);
    end
    rotor_done = 1'b1;
    tick();
    rotor_done = 1'b0;
    tick();
    chk("bp_drained", busy, 0);

    // reset in WAIT with three buffered
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(74 + i);
      in_valid = 1'b1;
      tick();
    end
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_err", in_err, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) tick();
    reset = 1'b0;
    ident_drv();
    tick();
    rotor_done = 1'b1;
    tick();
    rotor_done = 1'b0;
    b = ov_seen;
    repeat (4) tick();
    chk("post_rst_quiet", ov_seen - b, 0);
    issue_one("C", 8'h43, "post_rst");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 7) in_data = 8'(65 + $urandom_range(0, 25));
      else if (r == 7) in_data = 8'(97 + $urandom_range(0, 25));
      else in_data = 8'($urandom_range(0, 255));
      rotor_done = ($urandom_range(0, 3) == 0);
      set = ($urandom_range(0, 99) == 0);
      if (set) begin
        for (int k = 0; k < 26; k++) begin
          if ($urandom_range(0, 9) < 7)
            drv_tbl[k] = 8'(65 + $urandom_range(0, 25));
          else
            drv_tbl[k] = 8'($urandom_range(0, 255));
        end
        pairs = pack_tbl();
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    set = 1'b0;
    in_valid = 1'b0;
    rotor_done = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/plugboard.md
PLUGBOARD -- requirements
Module: plugboard

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: input character buffer depth, power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 set  input  1  load the swap table from pairs on this edge.
REQ-005 pairs  input  208  26 ASCII bytes; [207:200] = image of 'A', [199:192] = image of 'B', ... [7:0] = image of 'Z'.
REQ-006 in_valid  input  1  host character present.
REQ-007 in_data  input  8  host ASCII character.
REQ-008 in_ready  output  1  buffer can accept; a transfer occurs when in_valid and in_ready are both high.
REQ-009 out_valid  output  1  one-cycle pulse to the downstream rotor's valid input.
REQ-010 out_data  output  8  plugboard-mapped ASCII to the rotor's din.
REQ-011 rotor_done  input  1  rotor's done output; marks completion of the issued character.
REQ-012 busy  output  1  high when state is not IDLE or the buffer is non-empty.
REQ-013 in_err  output  1  one-cycle pulse when a rejected character is transferred.

Function
REQ-014 Accepted characters: 0x41..0x5A; any other transferred byte is dropped, not buffered, and pulses in_err on the following cycle.
REQ-015 Buffer: FIFO of FIFO_DEPTH bytes; in_ready = not full; push and pop in the same edge are permitted at any occupancy, and count stays unchanged.
REQ-016 FSM states: IDLE, ISSUE, WAIT.
REQ-017 IDLE -> ISSUE on an edge with a non-empty FIFO: pop the head, register table[head-0x41] into out_data.
REQ-018 ISSUE: out_valid = 1 for exactly this one cycle; -> WAIT on the next edge.
REQ-019 WAIT: -> IDLE on the first edge with rotor_done = 1; rotor_done in IDLE or ISSUE is ignored.
REQ-020 Latency: a character pushed at edge N appears with out_valid after edge N+1 when the FSM is IDLE and the FIFO is empty.
REQ-021 At most one character is outstanding at the rotor; the next pop occurs no earlier than the edge after WAIT exits.
REQ-022 out_data holds its value until the next pop.
REQ-023 Lookup: a table byte outside 0x41..0x5A maps its letter to itself (identity); the table is not required to be an involution.
REQ-024 set is accepted in every state; the new table applies to pops at edges strictly after the set edge; an in-flight out_data is unchanged.
REQ-025 set and an input transfer in the same cycle: both take effect; the character is mapped with the new table when popped.

Reset
REQ-026 While reset is high: out_valid = 0, out_data = 0x00, in_err = 0, in_ready = 0, busy = 0, FSM = IDLE, FIFO empty.
REQ-027 Reset loads the identity table, i.e. byte k = 0x41+k.
REQ-028 Reset mid-operation discards buffered and outstanding characters; a rotor_done arriving after release while IDLE has no effect.

Configuration
REQ-029 Macro PLUGBOARD_LOWERCASE_EN defined: 0x61..0x7A are accepted and folded to uppercase (minus 0x20) before buffering.
REQ-030 Macro PLUGBOARD_LOWERCASE_EN undefined: 0x61..0x7A are rejected per REQ-014.

Structure
REQ-031 Shared package enigma_pkg: ASCII_A = 65, ALPHA_LEN = 26, TABLE_W = 208, and the plugboard state enumeration.
REQ-032 One sub-module, plug_fifo (parameterised depth, byte wide, push/pop/full/empty/count).
REQ-033 Table lookup and state machine reside in plugboard.

Verification
REQ-034 Reset, then check the identity table: send 'C' (0x43) -> out_valid pulse two cycles later with out_data 0x43; busy stays high until a rotor_done pulse.
REQ-035 Swap table with byte0 = 0x51 and byte16 = 0x41: send 'A' -> out_data 0x51; send 'Q' -> out_data 0x41.
REQ-036 Push 6 characters back-to-back with rotor_done held low and FIFO_DEPTH = 4 -> one issued, 4 buffered, in_ready low, the 6th is stalled; each rotor_done releases exactly one further out_valid.
REQ-037 Send 0x31 then 'B' -> in_err pulses once; only 'B' issued.
REQ-038 Send 'a' (0x61) -> with the macro defined, out_data = table['A']; without it, in_err pulses and no out_valid.
REQ-039 Assert reset while in WAIT with 3 characters buffered -> all outputs at reset values; after release no out_valid until a new input is transferred.
